// File: rtl/serial_adder_ctrl_if.sv
// Bus bundle between the issuing logic, serial_adder_ctrl and the external adder slice.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow flag ovf.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Co;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif
  logic [DIGIT-1:0] add_a;
  logic [DIGIT-1:0] add_b;
  logic             add_ci;
  logic [DIGIT-1:0] add_s;
  logic             add_co;

`ifdef SERIAL_ADDER_OVF_EN
  modport master (
    output start, A, B, Ci, add_s, add_co,
    input  busy, done, S, Co, ovf, add_a, add_b, add_ci
  );

  modport slave (
    input  start, A, B, Ci, add_s, add_co,
    output busy, done, S, Co, ovf, add_a, add_b, add_ci
  );
`else
  modport master (
    output start, A, B, Ci, add_s, add_co,
    input  busy, done, S, Co, add_a, add_b, add_ci
  );

  modport slave (
    input  start, A, B, Ci, add_s, add_co,
    output busy, done, S, Co, add_a, add_b, add_ci
  );
`endif

endinterface

// File: rtl/serial_adder_ctrl.sv
// Digit-serial WIDTH-bit adder sequencer driving one external DIGIT-bit ripple slice, LSB digit first.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow flag (bus.ovf).
module serial_adder_ctrl #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic               clk,
  input logic               rst,
  serial_adder_ctrl_if.slave bus
);

  // WIDTH must be a whole multiple of DIGIT and at least one digit wide.
  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [KW-1:0]    r_k;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_co;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  logic w_accept;

  // DONE also accepts, so a held start restarts on the edge where done falls (one sum per N+1 cycles).
  assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  assign bus.add_a  = r_a[r_k*DIGIT +: DIGIT];
  assign bus.add_b  = r_b[r_k*DIGIT +: DIGIT];
  assign bus.add_ci = r_carry;

  assign bus.busy = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign bus.done = (r_state == ST_DONE);
  assign bus.S    = r_s;
  assign bus.Co   = r_co;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = r_ovf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state <= ST_RUN;
      r_k     <= '0;
      r_carry <= bus.Ci;
      r_a     <= bus.A;
      r_b     <= bus.B;
      r_s     <= '0;
      r_co    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_RUN: begin
          r_s[r_k*DIGIT +: DIGIT] <= bus.add_s;
          r_carry                 <= bus.add_co;
          if (r_k == K_LAST) begin
            r_co    <= bus.add_co;
            r_k     <= '0;
            r_state <= ST_DONE;
`ifdef SERIAL_ADDER_OVF_EN
            // The last slice sum bit is the result sign bit.
            r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                       (bus.add_s[DIGIT-1] != r_a[WIDTH-1]);
`endif
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=16, DIGIT=4 with a behavioural 4-bit adder slice.
// Covers SERIAL_ADDER_OVF_EN when that macro is defined.
module tb_serial_adder_ctrl;
  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
  } expT;

  logic clk = 1'b0;
  logic rst;
  expT  expQ[$];
  int   errors        = 0;
  int   checks        = 0;
  int   doneCount     = 0;
  int   expectedDones = 0;

  serial_adder_ctrl_if #(.WIDTH(WIDTH), .DIGIT(DIGIT)) bus ();

  serial_adder_ctrl #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Team 4-bit ripple adder stand-in.
  assign {bus.add_co, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0000, bus.add_ci};

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input logic [WIDTH-1:0] es, input logic eco, input logic eovf);
    expT e;
    e.s   = es;
    e.co  = eco;
    e.ovf = eovf;
    expQ.push_back(e);
    expectedDones++;
  endtask

  // Waits at negedges until done appears; returns cycles waited (bounded).
  task automatic waitDone(output int waitCyc, output int busyCyc);
    waitCyc = 0;
    busyCyc = bus.busy ? 1 : 0;
    while (!bus.done && waitCyc < 20) begin
      @(negedge clk);
      waitCyc++;
      if (bus.busy) busyCyc++;
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                               input logic [WIDTH-1:0] es, input logic eco, input logic eovf);
    int waitCyc;
    int busyCyc;
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.Ci    = ci;
    bus.start = 1'b1;
    pushExpected(es, eco, eovf);
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(waitCyc, busyCyc);
    checkOutput("done_latency", 32'(waitCyc), 32'(N));
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(bus.done), 32'd0);
    checkOutput("busy_after_done", 32'(bus.busy), 32'd0);
    checkOutput("busy_cycles", 32'(busyCyc), 32'(N + 1));
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    expT e;
    if (!rst && bus.done) begin
      doneCount++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spurious_done: got done=1, expected done=0 (nothing pending)");
      end else begin
        e = expQ.pop_front();
        checkOutput("sum_S", 32'(bus.S), 32'(e.s));
        checkOutput("sum_Co", 32'(bus.Co), 32'(e.co));
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("sum_ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waitCyc;
    int busyCyc;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Ci    = 1'b0;
    #12;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_S", 32'(bus.S), 32'd0);
    checkOutput("reset_Co", 32'(bus.Co), 32'd0);
    checkOutput("reset_add_a", 32'(bus.add_a), 32'd0);
    checkOutput("reset_add_ci", 32'(bus.add_ci), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] basic, carry and wrap vectors");
    applyStimulus(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    applyStimulus(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    $display("[TB] overflow vectors");
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    applyStimulus(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    applyStimulus(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("[TB] start held high with operands changing mid-run");
    @(negedge clk);
    bus.A     = 16'h0010;
    bus.B     = 16'h0020;
    bus.Ci    = 1'b0;
    bus.start = 1'b1;
    pushExpected(16'h0030, 1'b0, 1'b0);
    @(negedge clk);
    bus.A = 16'hFFFF;
    bus.B = 16'hFFFF;
    pushExpected(16'hFFFE, 1'b1, 1'b0);
    waitDone(waitCyc, busyCyc);
    checkOutput("held_first_latency", 32'(waitCyc), 32'(N));
    @(negedge clk);
    checkOutput("held_reaccept_busy", 32'(bus.busy), 32'd1);
    checkOutput("held_reaccept_done", 32'(bus.done), 32'd0);
    checkOutput("held_clear_S", 32'(bus.S), 32'd0);
    bus.start = 1'b0;
    waitDone(waitCyc, busyCyc);
    checkOutput("held_second_latency", 32'(waitCyc), 32'(N));
    @(negedge clk);
    checkOutput("held_idle_after", 32'(bus.busy), 32'd0);
    checkOutput("held_S_kept", 32'(bus.S), 32'hFFFE);

    $display("[TB] asynchronous reset during digit 2");
    @(negedge clk);
    bus.A     = 16'h1111;
    bus.B     = 16'h2222;
    bus.Ci    = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("partial_S", 32'(bus.S), 32'h0033);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_S", 32'(bus.S), 32'd0);
    checkOutput("abort_Co", 32'(bus.Co), 32'd0);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    applyStimulus(16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    checkOutput("done_count", 32'(doneCount), 32'(expectedDones));
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
